cache_tag_array: RTL
====================

Name: cache_tag_array

Overview:
Parametrised N-way set-associative tag store for the L1 cache controller, replacing the fixed 4-way, 11-bit-tag lookup.
- Adds per-line valid bits, a power-on/flush sweep that clears them, and victim selection (first invalid way, else a round-robin pointer per set).
- Adds a held hard-fault state that waits for the fill engine before writing the new tag.
- Sits between the CPU access pipeline and the DRAM fill/writeback engine.

Parameters:
WAYS, 4, number of ways; power of two, 2..8
SET_BITS, 11, log2 of the number of sets
TAG_BITS, 11, stored tag width
OFFSET_BITS, 4, line offset width; tag = target_address[OFFSET_BITS+SET_BITS+TAG_BITS-1 : OFFSET_BITS+SET_BITS]
ADDR_BITS, 31, target_address width; must be >= OFFSET_BITS+SET_BITS+TAG_BITS

Ports:
main_clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
target_address  in  ADDR_BITS  access address
in_valid  in  1  access request
is_no_access  in  1  probe only; a miss must not start a fill
fill_done  in  1  pulse: fill engine finished the line for the held fault
flush  in  1  pulse: invalidate all lines
out_ready  out  1  request accepted when in_valid && out_ready
out_result_valid  out  1  lookup result valid this cycle
out_hit  out  1  tag matched a valid way
out_way_index  out  log2(WAYS)  hit way, or victim way on a miss
out_any_fault  out  1  miss (any kind)
out_hard_fault  out  1  miss with is_no_access=0; held until fill_done
out_victim_tag  out  TAG_BITS  tag currently stored in the victim way (for writeback)
out_victim_valid  out  1  victim way holds a valid line

Behaviour:
- States: INIT, IDLE, FAULT. Reset (at any time, including mid-FAULT or mid-sweep) forces INIT with the sweep counter at 0. All outputs are 0 while in INIT.
- INIT: one set per cycle. Clears the valid bits of all ways and sets the RR pointer to 0. Takes 2^SET_BITS cycles, then goes to IDLE. flush in IDLE re-enters INIT; flush in FAULT or INIT is ignored.
- IDLE: out_ready = 1, except in a cycle where out_hard_fault is being asserted. A request presented in that cycle is not accepted.
- Lookup latency: 1 cycle. Request accepted in cycle N gives out_result_valid=1 in cycle N+1, with tag compare against the registered tag and the RAM read data. Back-to-back requests give one result per cycle.
- Hit: out_hit=1, out_way_index = lowest-numbered matching valid way (one-hot priority). No state change; the RR pointer is unchanged.
- Victim selection: lowest-numbered invalid way, else the set's RR pointer.
- Soft miss (is_no_access=1): out_any_fault=1 and out_way_index=victim, for one cycle only. No state change.
- Hard miss: out_hard_fault=1 and out_any_fault=1. Go to FAULT.
- FAULT state:
  - Hold out_result_valid, out_hard_fault, out_any_fault, out_way_index, out_victim_tag and out_victim_valid at the values captured in the faulting cycle. Keep out_ready=0.
  - On fill_done: write the saved tag to the victim way with valid=1. If the victim was chosen by the RR pointer, increment the pointer mod WAYS.
  - In the cycle after fill_done, clear the outputs and return to IDLE.
- fill_done outside FAULT: ignored.
- Read-after-fill: a lookup accepted in the first IDLE cycle after a fill, to the same set, must see the new tag. This needs no bypass path because the write completes before the read is issued.
- Storage: one tag+valid RAM per way and one RR-pointer RAM (log2(WAYS) bits x sets). All use synchronous read; writes are enabled only in INIT and on fill_done.

Decomposition:
- Package cache_pkg holds:
  - the state enum (INIT, IDLE, FAULT);
  - the functions tag_of(addr) and set_of(addr);
  - WAY_BITS = $clog2(WAYS);
  - the lowest-set-bit priority encoder function used for both the hit-way and the invalid-way selection.
- One sub-module, cache_tag_way_ram: single-way tag+valid synchronous RAM, instantiated WAYS times in a generate loop.

Test Plan:
- Reset, then hold in_valid=1 → out_ready=0 for exactly 2048 cycles, then 1; the first lookup at 0x0000_1230 → out_any_fault=1, out_victim_valid=0, out_way_index=0.
- Hard miss at 0x0004_8010, then fill_done 5 cycles later → out_hard_fault held for 5 cycles, out_ready=0 throughout; re-access of 0x0004_8010 → out_hit=1, way 0, 1-cycle latency.
- Fill 4 distinct tags into set 1, then a 5th tag → victim way 0 (RR=0), out_victim_tag = first tag, out_victim_valid=1; a 6th miss → victim way 1.
- Probe miss with is_no_access=1 → out_any_fault=1 for one cycle, out_hard_fault=0, out_ready stays 1, the next request is accepted the following cycle.
- Back-to-back hit, hit, hard miss, request → results in consecutive cycles; the 4th request is not accepted in the hard-fault cycle and is retried after fill_done.
- Assert reset during FAULT and flush during IDLE → INIT restarts from set 0; all lines read invalid afterwards.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative tag store.
package cache_pkg;

  localparam int unsigned MaxWays = 8;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StFault
  } state_e;

  // Results are wider than any field; callers truncate with a sized cast.
  function automatic logic [63:0] tag_of(input logic [63:0] addr, input int unsigned offset_bits,
                                         input int unsigned set_bits);
    return addr >> (offset_bits + set_bits);
  endfunction

  function automatic logic [63:0] set_of(input logic [63:0] addr, input int unsigned offset_bits);
    return addr >> offset_bits;
  endfunction

  // Index of the lowest set bit; 0 when none is set.
  function automatic logic [2:0] lowest_set(input logic [MaxWays-1:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = MaxWays - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_tag_array_if.sv
// Request/result bus between the CPU access pipeline, fill engine and the tag store.
interface cache_tag_array_if #(
  parameter int unsigned ADDR_BITS = 31,
  parameter int unsigned WAY_BITS  = 2,
  parameter int unsigned TAG_BITS  = 11
);
  logic [ADDR_BITS-1:0] target_address;
  logic                 in_valid;
  logic                 is_no_access;
  logic                 fill_done;
  logic                 flush;
  logic                 out_ready;
  logic                 out_result_valid;
  logic                 out_hit;
  logic [WAY_BITS-1:0]  out_way_index;
  logic                 out_any_fault;
  logic                 out_hard_fault;
  logic [TAG_BITS-1:0]  out_victim_tag;
  logic                 out_victim_valid;

  modport master (
    output target_address, in_valid, is_no_access, fill_done, flush,
    input  out_ready, out_result_valid, out_hit, out_way_index, out_any_fault, out_hard_fault,
           out_victim_tag, out_victim_valid
  );

  modport slave (
    input  target_address, in_valid, is_no_access, fill_done, flush,
    output out_ready, out_result_valid, out_hit, out_way_index, out_any_fault, out_hard_fault,
           out_victim_tag, out_victim_valid
  );
endinterface

// File: rtl/cache_tag_way_ram.sv
// One way of the tag store: {valid, tag} per set, synchronous read, single write port.
module cache_tag_way_ram #(
  parameter int unsigned SET_BITS = 11,
  parameter int unsigned TAG_BITS = 11
) (
  input  logic                main_clk,
  input  logic                re,
  input  logic [SET_BITS-1:0] raddr,
  output logic [TAG_BITS-1:0] rtag,
  output logic                rvalid,
  input  logic                we,
  input  logic [SET_BITS-1:0] waddr,
  input  logic [TAG_BITS-1:0] wtag,
  input  logic                wvalid
);

  logic [TAG_BITS:0] mem_q [2**SET_BITS];

  always_ff @(posedge main_clk) begin
    if (we) mem_q[waddr] <= {wvalid, wtag};
    if (re) {rvalid, rtag} <= mem_q[raddr];
  end

endmodule

// File: rtl/cache_tag_array.sv
// N-way set-associative tag store with init/flush sweep, victim selection and a held hard fault.
module cache_tag_array #(
  parameter int unsigned WAYS        = 4,
  parameter int unsigned SET_BITS    = 11,
  parameter int unsigned TAG_BITS    = 11,
  parameter int unsigned OFFSET_BITS = 4,
  parameter int unsigned ADDR_BITS   = 31
) (
  input logic              main_clk,
  input logic              reset,
  cache_tag_array_if.slave bus
);
  import cache_pkg::*;

  localparam int unsigned WAY_BITS = $clog2(WAYS);
  localparam int unsigned SETS     = 2 ** SET_BITS;

  state_e                state_q, state_d;
  logic [SET_BITS-1:0]   sweep_q, sweep_d;
  logic                  req_q, probe_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [SET_BITS-1:0]   set_q;
  logic [WAY_BITS-1:0]   flt_way_q;
  logic [TAG_BITS-1:0]   flt_vtag_q;
  logic                  flt_vvalid_q, flt_by_rr_q;

  logic [ADDR_BITS-1:0]  addr;
  logic [SET_BITS-1:0]   req_set;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  ready, accept;
  logic [TAG_BITS-1:0]   rd_tag [WAYS];
  logic [WAYS-1:0]       rd_valid, hit_vec, way_we;
  logic [WAY_BITS-1:0]   rr_rd_q, rr_wdata, hit_way, victim;
  logic [WAY_BITS-1:0]   rr_mem_q [SETS];
  logic                  hit, any_inv, res_valid, res_hard;
  logic                  init_we, fill_we, rr_we;
  logic [SET_BITS-1:0]   waddr;

  assign addr    = bus.target_address;
  assign req_tag = TAG_BITS'(tag_of(64'(addr), OFFSET_BITS, SET_BITS));
  assign req_set = SET_BITS'(set_of(64'(addr), OFFSET_BITS));
  assign accept  = bus.in_valid && ready;

  // Lookup stage: compare the registered tag against this cycle's RAM read data.
  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = rd_valid[w] && (rd_tag[w] == tag_q);
    end
    hit       = |hit_vec;
    any_inv   = ~&rd_valid;
    hit_way   = WAY_BITS'(lowest_set(MaxWays'(hit_vec)));
    victim    = any_inv ? WAY_BITS'(lowest_set(MaxWays'(~rd_valid))) : rr_rd_q;
    res_valid = (state_q == StIdle) && req_q;
    res_hard  = res_valid && !hit && !probe_q;
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      StInit: begin
        sweep_d = sweep_q + SET_BITS'(1);
        if (sweep_q == SET_BITS'(SETS - 1)) state_d = StIdle;
      end
      StIdle: begin
        if (bus.flush) begin
          state_d = StInit;
          sweep_d = '0;
        end else if (res_hard) begin
          state_d = StFault;
        end
      end
      StFault: begin
        if (bus.fill_done) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    ready                = 1'b0;
    bus.out_result_valid = 1'b0;
    bus.out_hit          = 1'b0;
    bus.out_way_index    = '0;
    bus.out_any_fault    = 1'b0;
    bus.out_hard_fault   = 1'b0;
    bus.out_victim_tag   = '0;
    bus.out_victim_valid = 1'b0;
    case (state_q)
      StIdle: begin
        ready                = !res_hard;
        bus.out_result_valid = res_valid;
        bus.out_hit          = res_valid && hit;
        bus.out_any_fault    = res_valid && !hit;
        bus.out_hard_fault   = res_hard;
        if (res_valid) begin
          bus.out_way_index    = hit ? hit_way : victim;
          bus.out_victim_tag   = rd_tag[victim];
          bus.out_victim_valid = rd_valid[victim];
        end
      end
      StFault: begin
        bus.out_result_valid = 1'b1;
        bus.out_any_fault    = 1'b1;
        bus.out_hard_fault   = 1'b1;
        bus.out_way_index    = flt_way_q;
        bus.out_victim_tag   = flt_vtag_q;
        bus.out_victim_valid = flt_vvalid_q;
      end
      default: ;
    endcase
  end

  assign bus.out_ready = ready;

  assign init_we  = (state_q == StInit);
  assign fill_we  = (state_q == StFault) && bus.fill_done;
  assign waddr    = init_we ? sweep_q : set_q;
  assign rr_we    = init_we || (fill_we && flt_by_rr_q);
  assign rr_wdata = init_we ? '0 : flt_way_q + WAY_BITS'(1);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_we[w] = init_we || (fill_we && (flt_way_q == WAY_BITS'(w)));

    cache_tag_way_ram #(
      .SET_BITS (SET_BITS),
      .TAG_BITS (TAG_BITS)
    ) u_ram (
      .main_clk (main_clk),
      .re       (accept),
      .raddr    (req_set),
      .rtag     (rd_tag[w]),
      .rvalid   (rd_valid[w]),
      .we       (way_we[w]),
      .waddr    (waddr),
      .wtag     (init_we ? '0 : tag_q),
      .wvalid   (!init_we)
    );
  end

  always_ff @(posedge main_clk) begin
    if (rr_we) rr_mem_q[waddr] <= rr_wdata;
    if (accept) rr_rd_q <= rr_mem_q[req_set];
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q      <= StInit;
      sweep_q      <= '0;
      req_q        <= 1'b0;
      probe_q      <= 1'b0;
      tag_q        <= '0;
      set_q        <= '0;
      flt_way_q    <= '0;
      flt_vtag_q   <= '0;
      flt_vvalid_q <= 1'b0;
      flt_by_rr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      req_q   <= accept;
      if (accept) begin
        tag_q   <= req_tag;
        set_q   <= req_set;
        probe_q <= bus.is_no_access;
      end
      // Tag and set stay in tag_q/set_q: nothing is accepted while faulted.
      if (state_q == StIdle && state_d == StFault) begin
        flt_way_q    <= victim;
        flt_vtag_q   <= rd_tag[victim];
        flt_vvalid_q <= rd_valid[victim];
        flt_by_rr_q  <= !any_inv;
      end
    end
  end

endmodule
